// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and lane helpers for the MEM-stage data memory
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_RSVD = 2'b00,
        SZ_WORD = 2'b01,
        SZ_HALF = 2'b10,
        SZ_BYTE = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_e;

    function automatic logic [31:0] lane_extend(input logic [31:0] word,
                                                input mem_size_e   size,
                                                input logic [1:0]  addr_lo,
                                                input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{addr_lo, 3'b000} +: 8];
        h = word[{addr_lo[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: return {{24{b[7] & ~uns}}, b};
            SZ_HALF: return {{16{h[15] & ~uns}}, h};
            default: return word;
        endcase
    endfunction

    // Range is depth-dependent and checked by the caller; this covers size and alignment.
    function automatic logic check_err(input logic [1:0] addr_lo, input mem_size_e size);
        case (size)
            SZ_WORD: return addr_lo != 2'b00;
            SZ_HALF: return addr_lo[0];
            SZ_BYTE: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ctrl_array.sv
// rtl/data_mem_ctrl_array.sv - word storage with byte-enable write and registered read
module dmem_array #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we_i,
    input  logic [3:0]                     be_i,
    input  logic                           re_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic [31:0]                    wdata_i,
    output logic [31:0]                    rdata_o
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        if (re_i) rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - clocked MEM-stage data memory with handshake and load latency
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int READ_LAT    = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int IW = $clog2(DEPTH_WORDS);

    dmem_state_e state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    mem_size_e   size_q;
    logic [1:0]  addr_lo_q;
    logic        uns_q, err_q, write_q;

    mem_size_e   req_size_e;
    logic        oor, req_err, accept;
    logic [3:0]  be;
    logic [31:0] wdata, arr_rdata;

    assign req_size_e = mem_size_e'(req_size);

    always_comb begin
        oor = 1'b0;
        for (int b = IW + 2; b < ADDR_W; b++) oor = oor | req_addr[b];
    end

    assign req_err   = oor || check_err(req_addr[1:0], req_size_e);
    assign req_ready = (state_q == IDLE) && reset_n;
    assign accept    = req_valid && req_ready;

    // Narrow stores replicate their data across lanes; the byte enables pick the target.
    always_comb begin
        be    = 4'b1111;
        wdata = req_wdata;
        case (req_size_e)
            SZ_HALF: begin
                be    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{req_wdata[15:0]}};
            end
            SZ_BYTE: begin
                be    = 4'b0001 << req_addr[1:0];
                wdata = {4{req_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk     (clk),
        .we_i    (accept && req_write && !req_err),
        .be_i    (be),
        .re_i    (accept && !req_write && !req_err),
        .addr_i  (req_addr[IW+1:2]),
        .wdata_i (wdata),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err || req_write || READ_LAT == 1) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = 2'(READ_LAT - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 2'd1) state_d = RESP;
                else               cnt_d   = cnt_q - 2'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            size_q    <= SZ_RSVD;
            addr_lo_q <= 2'b00;
            uns_q     <= 1'b0;
            err_q     <= 1'b0;
            write_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                size_q    <= req_size_e;
                addr_lo_q <= req_addr[1:0];
                uns_q     <= req_unsigned;
                err_q     <= req_err;
                write_q   <= req_write;
            end
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !err_q && !write_q)
                       ? lane_extend(arr_rdata, size_q, addr_lo_q, uns_q) : 32'h0;

endmodule
